// File: rtl/mem_access_unit.sv
// Load/store initiator between the execute stage and a word-addressed data memory.
// Sub-word stores are read-modify-write; every memory-side output is driven from a flop.
module mem_access_unit #(
  parameter int Width = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req,
  input  logic             we,
  input  logic [1:0]       size,
  input  logic             unsigned_ld,
  input  logic [Width-1:0] addr,
  input  logic [Width-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [Width-1:0] rdata,
  output logic             MemRead,
  output logic             MemWrite,
  output logic [Width-1:0] mem_addr,
  output logic [Width-1:0] mem_wdata,
  input  logic [Width-1:0] mem_rdata
);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_READ  = 2'b01,
    S_WRITE = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  state_t           r_state;
  state_t           w_next;

  logic             r_busy;
  logic             r_done;
  logic             r_err;
  logic             r_mem_read;
  logic             r_mem_write;
  logic [Width-1:0] r_rdata;
  logic [Width-1:0] r_mem_addr;
  logic [Width-1:0] r_mem_wdata;

  logic             r_we;
  logic [1:0]       r_size;
  logic             r_uns;
  logic [1:0]       r_lane;
  logic [15:0]      r_wdata;

  logic             w_accept;
  logic             w_illegal;
  logic             w_word_store;

  function automatic logic is_illegal(input logic [1:0] sz, input logic [1:0] lo);
    logic bad;
    bad = 1'b0;
    case (sz)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = lo[0];
      SZ_WORD: bad = (lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [Width-1:0] load_ext(input logic [Width-1:0] word,
                                                input logic [1:0]       sz,
                                                input logic [1:0]       lane,
                                                input logic             uns);
    logic [7:0]       b;
    logic [15:0]      h;
    logic [Width-1:0] res;
    b   = word[{lane, 3'b000} +: 8];
    h   = word[{lane[1], 4'b0000} +: 16];
    res = word;
    case (sz)
      SZ_BYTE: res = {{(Width-8){~uns & b[7]}}, b};
      SZ_HALF: res = {{(Width-16){~uns & h[15]}}, h};
      default: res = word;
    endcase
    return res;
  endfunction

  function automatic logic [Width-1:0] merge_store(input logic [Width-1:0] word,
                                                   input logic [15:0]      wd,
                                                   input logic [1:0]       sz,
                                                   input logic [1:0]       lane);
    logic [Width-1:0] res;
    res = word;
    case (sz)
      SZ_BYTE: res[{lane, 3'b000} +: 8]     = wd[7:0];
      SZ_HALF: res[{lane[1], 4'b0000} +: 16] = wd;
      default: res = word;
    endcase
    return res;
  endfunction

  assign w_illegal    = is_illegal(size, addr[1:0]);
  assign w_accept     = (r_state == S_IDLE) && req;
  assign w_word_store = we && (size == SZ_WORD);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (req) begin
          if (w_illegal)         w_next = S_DONE;
          else if (w_word_store) w_next = S_WRITE;
          else                   w_next = S_READ;
        end
      end
      S_READ:  w_next = r_we ? S_WRITE : S_DONE;
      S_WRITE: w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Request fields are only consumed after acceptance, so they need no reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_we    <= we;
      r_size  <= size;
      r_uns   <= unsigned_ld;
      r_lane  <= addr[1:0];
      r_wdata <= wdata[15:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_rdata     <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_state     <= w_next;
      r_busy      <= (w_next != S_IDLE);
      r_done      <= (w_next == S_DONE);
      r_err       <= w_accept && w_illegal;
      r_mem_read  <= (w_next == S_READ);
      r_mem_write <= (w_next == S_WRITE);
      if (w_accept && !w_illegal) begin
        r_mem_addr <= {2'b00, addr[Width-1:2]};
        if (w_word_store) r_mem_wdata <= wdata;
      end
      // The word read here serves as the RMW buffer: it is merged straight into mem_wdata.
      if (r_state == S_READ) begin
        if (r_we) r_mem_wdata <= merge_store(mem_rdata, r_wdata, r_size, r_lane);
        else      r_rdata     <= load_ext(mem_rdata, r_size, r_lane, r_uns);
      end
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;
  assign rdata     = r_rdata;
  assign MemRead   = r_mem_read;
  assign MemWrite  = r_mem_write;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store initiator that sits between the core's execute stage and the word-addressed data memory. It accepts one byte-addressed load or store request at a time, turns it into word-granular MemRead/MemWrite accesses, and returns sign- or zero-extended load data. Sub-word stores are performed as read-modify-write. All memory-side outputs come from flops, so the level-sensitive memory never sees a glitching strobe or address.

## Interface
- Width, 32, data and address width; only 32 is supported.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  1  request strobe; sampled only while busy=0.
- we  in  1  1 = store, 0 = load.
- size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- unsigned_ld  in  1  1 = zero-extend load, 0 = sign-extend load.
- addr  in  Width  byte address.
- wdata  in  Width  store data, right-aligned.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse coincident with done on a rejected request.
- rdata  out  Width  load result; holds until the next load completes.
- MemRead  out  1  memory read strobe.
- MemWrite  out  1  memory write strobe.
- mem_addr  out  Width  word address = {2'b00, addr[Width-1:2]}.
- mem_wdata  out  Width  word to write.
- mem_rdata  in  Width  memory read data, combinational from mem_addr.

## Operation
- States: IDLE, READ, WRITE, DONE.
- Transitions:
  - IDLE, req=1: latch we, size, unsigned_ld, addr and wdata, then check alignment.
  - Illegal request goes IDLE→DONE with err=1 and no memory access. Illegal means size=11, half with addr[0]=1, or word with addr[1:0]≠0.
  - Load: IDLE→READ→DONE.
  - Word store: IDLE→WRITE→DONE.
  - Byte or half store: IDLE→READ→WRITE→DONE.
  - DONE→IDLE unconditionally.
- READ: MemRead=1. mem_rdata is captured into an internal word buffer at the clock edge that ends the cycle.
- WRITE: MemWrite=1 and mem_wdata is stable for the whole cycle.
  - Word store: mem_wdata = wdata.
  - Sub-word store: mem_wdata = buffer with the addressed lane replaced by wdata[7:0] or wdata[15:0].
- Lanes are little-endian.
  - Byte lane = addr[1:0], bits [8*lane+7 : 8*lane].
  - Half lane = addr[1], bits [16*addr[1]+15 : 16*addr[1]].
- Load result: the selected lane is extended per unsigned_ld. rdata is updated in the cycle that enters DONE, only for successful loads.
- MemRead and MemWrite are never high together. Both are 0 in IDLE and DONE.
- mem_addr changes only at a clock edge where the next state is READ or WRITE. It holds its value otherwise.
- req while busy=1 is ignored, with no queueing. The requester holds req until it sees done.
- Reset:
  - state=IDLE; busy, done, err, MemRead and MemWrite = 0; rdata, mem_addr and mem_wdata = 0.
  - Reset takes effect immediately and asynchronously, including mid-access. A store aborted in READ never writes. A store aborted in WRITE may already have updated memory, and this is accepted.

## Timing
- Cycle 0 is the edge where req is sampled in IDLE.
- Load: MemRead is high in cycle 1; done and valid rdata in cycle 2.
- Word store: MemWrite in cycle 1; done in cycle 2.
- Sub-word store: MemRead in cycle 1, MemWrite in cycle 2, done in cycle 3.
- Rejected request: done=err=1 in cycle 1.
- Minimum spacing is one idle cycle after DONE. A new req is sampled at the edge ending DONE+1 (IDLE).
- All outputs are registered. There is no combinational path from req, addr or mem_rdata to any output.

## Test plan
- Reset: hold rst_n=0 mid-simulation → all outputs 0 within the same cycle, busy=0, state IDLE on release.
- Word load:
  - Stimulus: preload word 4=0x00000009, then lw addr=0x10.
  - Required response: MemRead=1 only in cycle 1 with mem_addr=4; done in cycle 2 with rdata=0x00000009.
  - A second req pulsed in cycle 1 is ignored.
- Sub-word loads, with word 6=0x80FF7F05:
  - lb 0x1B → 0xFFFFFF80.
  - lbu 0x1B → 0x00000080.
  - lh 0x18 → 0x00007F05.
  - lh 0x1A → 0xFFFF80FF.
  - lhu 0x1A → 0x000080FF.
- Byte store RMW:
  - Stimulus: word 3=0x00000003, sb wdata=0x123456AB addr=0x0D.
  - Required response: READ in cycle 1, then WRITE in cycle 2 with mem_wdata=0x0000AB03, done in cycle 3.
  - Follow-up lw 0x0C returns 0x0000AB03.
- Misaligned: lw 0x06 → done=err=1 in cycle 1, MemRead and MemWrite never asserted, rdata unchanged. Same for sh 0x05 and size=11.
- Reset mid-RMW:
  - Stimulus: sh 0xBEEF to 0x08 (word 2=0x00000002), with rst_n=0 asserted during the READ cycle.
  - Required response: MemWrite never rises, a later lw 0x08 returns 0x00000002, busy=0.
